hub75_scan_scheduler: RTL and testbench

Sequences one HUB75 LED-matrix panel in bit-plane (binary code modulation) order: fetches pixel bits from the frame buffer, shifts one row's columns into the panel, latches them, drives the row address and holds OE_N low for a plane-weighted on-time. It sits between the frame-buffer read port and the panel pins, inside `screen_controller`, clocked from the PLL output `sys_clk`. It replaces free-running per-pin logic with a single scheduler that owns all panel timing.

---
 rtl/hub75_scan_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_hub75_scan_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_scheduler.sv
// HUB75 panel scheduler: walks rows and bit-planes (binary code modulation), prefetches pixel bits,
// shifts them into the panel, latches, and holds OE_N low for a plane-weighted on-time.
module hub75_scan_scheduler #(
  parameter int unsigned COLS     = 64,
  parameter int unsigned ROW_BITS = 5,
  parameter int unsigned PLANES   = 8,
  parameter int unsigned BASE_ON  = 4,
  localparam int unsigned ColW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned PlaneW  = (PLANES > 1) ? $clog2(PLANES) : 1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  output logic                rd_en,
  output logic [ROW_BITS-1:0] rd_row,
  output logic [ColW-1:0]     rd_col,
  output logic [PlaneW-1:0]   rd_plane,
  input  logic [5:0]          rd_data,
  output logic                R1_data,
  output logic                G1_data,
  output logic                B1_data,
  output logic                R2_data,
  output logic                G2_data,
  output logic                B2_data,
  output logic                clk_out,
  output logic                LAT,
  output logic                OE_N,
  output logic [ROW_BITS-1:0] row_addr,
  output logic                frame_done
);

  localparam int unsigned MaxOn = BASE_ON << (PLANES - 1);
  localparam int unsigned OnW   = $clog2(MaxOn + 1);

  localparam logic [ColW-1:0]     ColLast   = ColW'(COLS - 1);
  localparam logic [PlaneW-1:0]   PlaneLast = PlaneW'(PLANES - 1);
  localparam logic [ROW_BITS-1:0] RowLast   = {ROW_BITS{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StPrefetch,
    StShift,
    StBlank,
    StLatch,
    StDisplay
  } state_e;

  state_e              state_q;
  logic [ROW_BITS-1:0] row_q;
  logic [PlaneW-1:0]   plane_q;
  logic [ColW-1:0]     col_q;
  logic                ph_q;
  logic [OnW-1:0]      on_cnt_q;
  logic                rd_en_q;
  logic [ColW-1:0]     rd_col_q;
  logic [5:0]          rgb_q;
  logic                clk_out_q;
  logic                lat_q;
  logic                oe_n_q;
  logic [ROW_BITS-1:0] row_addr_q;
  logic                frame_done_q;

  // Every output is a flop. Reads are issued one cycle ahead so rd_data lands in SHIFT ph=0;
  // the shift clock rises at the end of ph=1, giving the colour bits a full cycle either side.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= StIdle;
      row_q        <= '0;
      plane_q      <= '0;
      col_q        <= '0;
      ph_q         <= 1'b0;
      on_cnt_q     <= '0;
      rd_en_q      <= 1'b0;
      rd_col_q     <= '0;
      rgb_q        <= '0;
      clk_out_q    <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rd_en_q      <= 1'b0;
      clk_out_q    <= 1'b0;
      lat_q        <= 1'b0;
      frame_done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q  <= StPrefetch;
            row_q    <= '0;
            plane_q  <= '0;
            rd_en_q  <= 1'b1;
            rd_col_q <= '0;
          end
        end

        StPrefetch: begin
          state_q <= StShift;
          col_q   <= '0;
          ph_q    <= 1'b0;
        end

        StShift: begin
          if (!ph_q) begin
            rgb_q <= rd_data;
            ph_q  <= 1'b1;
            if (col_q != ColLast) begin
              rd_en_q  <= 1'b1;
              rd_col_q <= col_q + ColW'(1);
            end
          end else begin
            ph_q      <= 1'b0;
            clk_out_q <= 1'b1;
            if (col_q != ColLast) begin
              col_q <= col_q + ColW'(1);
            end else begin
              state_q    <= StBlank;
              row_addr_q <= row_q;
            end
          end
        end

        StBlank: begin
          state_q <= StLatch;
          lat_q   <= 1'b1;
        end

        StLatch: begin
          state_q  <= StDisplay;
          oe_n_q   <= 1'b0;
          on_cnt_q <= OnW'(BASE_ON << plane_q);
        end

        StDisplay: begin
          if (on_cnt_q > OnW'(1)) begin
            on_cnt_q <= on_cnt_q - OnW'(1);
          end else begin
            on_cnt_q <= '0;
            oe_n_q   <= 1'b1;
            if (plane_q != PlaneLast) begin
              plane_q  <= plane_q + PlaneW'(1);
              state_q  <= StPrefetch;
              rd_en_q  <= 1'b1;
              rd_col_q <= '0;
            end else begin
              plane_q <= '0;
              row_q   <= row_q + ROW_BITS'(1);
              if ((row_q == RowLast) && !enable) begin
                state_q <= StIdle;
              end else begin
                state_q  <= StPrefetch;
                rd_en_q  <= 1'b1;
                rd_col_q <= '0;
              end
              if (row_q == RowLast) begin
                frame_done_q <= 1'b1;
              end
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_row     = row_q;
  assign rd_col     = rd_col_q;
  assign rd_plane   = plane_q;
  assign R1_data    = rgb_q[5];
  assign G1_data    = rgb_q[4];
  assign B1_data    = rgb_q[3];
  assign R2_data    = rgb_q[2];
  assign G2_data    = rgb_q[1];
  assign B2_data    = rgb_q[0];
  assign clk_out    = clk_out_q;
  assign LAT        = lat_q;
  assign OE_N       = oe_n_q;
  assign row_addr   = row_addr_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Directed bench for hub75_scan_scheduler with COLS=4, ROW_BITS=1, PLANES=2, BASE_ON=2 and a
// one-cycle-latency frame buffer; a negedge monitor logs panel events for later checking.
module tb_hub75_scan_scheduler;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       rd_en;
  logic [0:0] rd_row;
  logic [1:0] rd_col;
  logic [0:0] rd_plane;
  logic [5:0] rd_data;
  logic       r1, g1, b1, r2, g2, b2;
  logic       clk_out;
  logic       lat;
  logic       oe_n;
  logic [0:0] row_addr;
  logic       frame_done;

  hub75_scan_scheduler #(
    .COLS    (4),
    .ROW_BITS(1),
    .PLANES  (2),
    .BASE_ON (2)
  ) dut (
    .clk_in    (clk),
    .reset     (reset),
    .enable    (enable),
    .rd_en     (rd_en),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_plane  (rd_plane),
    .rd_data   (rd_data),
    .R1_data   (r1),
    .G1_data   (g1),
    .B1_data   (b1),
    .R2_data   (r2),
    .G2_data   (g2),
    .B2_data   (b2),
    .clk_out   (clk_out),
    .LAT       (lat),
    .OE_N      (oe_n),
    .row_addr  (row_addr),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] pix(input logic r, input logic [1:0] c, input logic p);
    if (r == 1'b1 && c == 2'd2 && p == 1'b1) return 6'b101010;
    return {1'b0, r, c, p, 1'b1};
  endfunction

  // Frame buffer: data valid the cycle after rd_en.
  always @(posedge clk) rd_data <= rd_en ? pix(rd_row[0], rd_col, rd_plane[0]) : 6'h00;

  typedef struct {int cyc; logic [5:0] d;} rise_t;
  typedef struct {int cyc; logic row; logic plane; logic ra;} pf_t;

  int    cyc = 0;
  bit    mon_en = 1'b0;
  rise_t rise_q[$];
  pf_t   pf_q[$];
  int    fd_q[$];
  int    oe_runs[$];
  int    run = 0;
  int    rd_total = 0;
  int    bad = 0;
  logic  clk_prev = 1'b0, oe_prev = 1'b1, lat_prev = 1'b0, ra_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (clk_out && !clk_prev) rise_q.push_back('{cyc, {r1, g1, b1, r2, g2, b2}});
      if (rd_en) begin
        rd_total <= rd_total + 1;
        if (rd_col == 2'd0) pf_q.push_back('{cyc, rd_row[0], rd_plane[0], row_addr[0]});
      end
      if (frame_done) fd_q.push_back(cyc);
      if (!oe_n) begin
        run <= run + 1;
        // A run must start right after a single-cycle LAT pulse.
        if (oe_prev && !(lat_prev && !lat)) bad <= bad + 1;
      end else if (run != 0) begin
        oe_runs.push_back(run);
        run <= 0;
      end
      if (lat && (lat_prev || !oe_n)) bad <= bad + 1;
      if ((clk_out != clk_prev) && !oe_n) bad <= bad + 1;
      if ((row_addr[0] != ra_prev) && !oe_n) bad <= bad + 1;
    end
    clk_prev <= clk_out;
    oe_prev  <= oe_n;
    lat_prev <= lat;
    ra_prev  <= row_addr[0];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic at_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fd(input int n, input int limit);
    while (fd_q.size() < n && cyc < limit) begin
      @(posedge clk);
      #1;
    end
    check_eq("frame_done_seen", 32'(fd_q.size() >= n), 1);
  endtask

  int p0;
  int p_rst;
  int exp_runs[4] = '{2, 4, 2, 4};

  initial begin
    reset  = 1'b1;
    enable = 1'b0;

    // Reset values.
    at_cyc(3);
    mon_en = 1'b1;
    check_eq("rst_oe_n", 32'(oe_n), 1);
    check_eq("rst_lat", 32'(lat), 0);
    check_eq("rst_clk_out", 32'(clk_out), 0);
    check_eq("rst_row_addr", 32'(row_addr), 0);
    check_eq("rst_rd_en", 32'(rd_en), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_colour", 32'({r1, g1, b1, r2, g2, b2}), 0);

    // Single frame, enable dropped 10 cycles in.
    enable = 1'b1;
    reset  = 1'b0;
    at_cyc(14);
    enable = 1'b0;
    wait_fd(1, 200);
    check_eq("idle_to_prefetch", 32'(pf_q[0].cyc), 4);
    check_eq("frame_len", 32'(fd_q[0] - pf_q[0].cyc), 56);
    at_cyc(fd_q[0] + 1);
    check_eq("idle_oe_n", 32'(oe_n), 1);
    at_cyc(fd_q[0] + 20);
    check_eq("frame_prefetches", 32'(pf_q.size()), 4);
    check_eq("frame_reads", 32'(rd_total), 16);
    check_eq("frame_rises", 32'(rise_q.size()), 16);
    for (int b = 0; b < 4; b++) begin
      check_eq("burst_row", 32'(pf_q[b].row), 32'(b / 2));
      check_eq("burst_plane", 32'(pf_q[b].plane), 32'(b % 2));
      for (int k = 0; k < 4; k++) begin
        check_eq("rise_cyc", 32'(rise_q[4 * b + k].cyc), 32'(pf_q[b].cyc + 2 * k + 3));
        check_eq("rise_data", 32'(rise_q[4 * b + k].d),
                 32'(pix(1'(b / 2), 2'(k), 1'(b % 2))));
      end
    end
    check_eq("order_101010", 32'(rise_q[14].d), 32'(6'b101010));
    for (int i = 0; i < 4; i++) check_eq("oe_run", 32'(oe_runs[i]), 32'(exp_runs[i]));
    check_eq("row_addr_r1p0", 32'(pf_q[2].ra), 0);
    check_eq("row_addr_r1p1", 32'(pf_q[3].ra), 1);

    // Enable dropped 20 cycles into a frame.
    enable = 1'b1;
    at_cyc(cyc + 1);
    p0 = cyc;
    at_cyc(p0 + 20);
    enable = 1'b0;
    wait_fd(2, p0 + 200);
    check_eq("drop_prefetch_cyc", 32'(pf_q[4].cyc), 32'(p0));
    check_eq("drop_frame_len", 32'(fd_q[1] - p0), 56);
    at_cyc(fd_q[1] + 30);
    check_eq("drop_no_more_prefetch", 32'(pf_q.size()), 8);
    check_eq("drop_no_more_reads", 32'(rd_total), 32);

    // Reset pulse during row 1, plane 1 DISPLAY.
    enable = 1'b1;
    at_cyc(cyc + 1);
    p_rst = cyc;
    at_cyc(p_rst + 53);
    check_eq("pre_rst_oe_low", 32'(oe_n), 0);
    check_eq("pre_rst_plane", 32'(rd_plane), 1);
    check_eq("pre_rst_row_addr", 32'(row_addr), 1);
    reset = 1'b1;
    at_cyc(p_rst + 54);
    reset = 1'b0;
    check_eq("mid_rst_oe_n", 32'(oe_n), 1);
    check_eq("mid_rst_lat", 32'(lat), 0);
    check_eq("mid_rst_clk_out", 32'(clk_out), 0);
    check_eq("mid_rst_row_addr", 32'(row_addr), 0);
    check_eq("mid_rst_rd_en", 32'(rd_en), 0);
    at_cyc(p_rst + 55);
    check_eq("restart_rd_en", 32'(rd_en), 1);
    check_eq("restart_row", 32'(rd_row), 0);
    check_eq("restart_plane", 32'(rd_plane), 0);
    check_eq("restart_col", 32'(rd_col), 0);
    check_eq("restart_no_frame_done", 32'(fd_q.size()), 2);

    // Back-to-back frames with enable held.
    wait_fd(4, p_rst + 400);
    check_eq("b2b_first_len", 32'(fd_q[2] - pf_q[12].cyc), 56);
    check_eq("b2b_period", 32'(fd_q[3] - fd_q[2]), 56);
    check_eq("b2b_no_gap", 32'(pf_q[16].cyc), 32'(fd_q[2]));
    check_eq("b2b_last_row", 32'(pf_q[15].row), 1);
    check_eq("b2b_row_wrap", 32'(pf_q[16].row), 0);
    enable = 1'b0;
    at_cyc(fd_q[3] + 80);
    check_eq("panel_invariants", 32'(bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
